// File: rtl/dac5571_wave_sched.sv
// Waveform scheduler for a DAC5571 write engine: on every update tick it computes
// the next code (hold, sawtooth or triangle) and hands it to the engine.
`timescale 1ns/1ps
module dac5571_wave_sched #(
  parameter int UPDATE_DIV  = 50_000,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic       sclk,
  input  logic       nrst,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [7:0] step,
  input  logic [7:0] hold_vol,
  output logic [7:0] voltage,
  output logic       set_trig,
  input  logic       set_done,
  output logic [7:0] cur_vol,
  output logic       busy,
  output logic       err,
  output logic       overrun
);

  localparam int CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(UPDATE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] MODE_SAW = 2'b01;
  localparam logic [1:0] MODE_TRI = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [7:0]       voltage_q, voltage_d;
  logic [7:0]       cur_vol_q, cur_vol_d;
  logic             set_trig_q, set_trig_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             overrun_q, overrun_d;
  logic             dir_down_q, dir_down_d;
  logic             first_wr_q, first_wr_d;
  logic             en_prev_q, en_prev_d;

  logic       tick;
  logic       en_rise;
  logic       writing;
  logic [8:0] sum9;
  logic [7:0] tri_up;
  logic [7:0] tri_dn;
  logic [7:0] wave_next;
  logic       dir_next;
  logic       hold_mode;
  logic       hold_skip;

  assign tick    = (state_q != IDLE) && (cnt_q == CNT_MAX);
  assign en_rise = enable & ~en_prev_q;
  assign writing = (state_q == ISSUE) || (state_q == WAIT_DONE);

  // Triangle rising edge saturates at full scale via the 9-bit carry.
  assign sum9   = {1'b0, cur_vol_q} + {1'b0, step};
  assign tri_up = sum9[8] ? 8'hFF : sum9[7:0];
  assign tri_dn = (cur_vol_q >= step) ? (cur_vol_q - step) : 8'h00;

  always_comb begin
    wave_next = hold_vol;
    dir_next  = dir_down_q;
    case (mode)
      MODE_SAW: wave_next = sum9[7:0];
      MODE_TRI: begin
        if (!dir_down_q) begin
          wave_next = tri_up;
          if (tri_up == 8'hFF) dir_next = 1'b1;
        end else begin
          wave_next = tri_dn;
          if (tri_dn == 8'h00) dir_next = 1'b0;
        end
      end
      default: wave_next = hold_vol;
    endcase
  end

  assign hold_mode = (mode != MODE_SAW) && (mode != MODE_TRI);
  assign hold_skip = hold_mode && (wave_next == cur_vol_q) && !first_wr_q;

  always_comb begin
    state_d    = state_q;
    to_d       = to_q;
    voltage_d  = voltage_q;
    cur_vol_d  = cur_vol_q;
    set_trig_d = 1'b0;
    busy_d     = busy_q;
    err_d      = 1'b0;
    overrun_d  = overrun_q;
    dir_down_d = dir_down_q;
    first_wr_d = first_wr_q;
    en_prev_d  = enable;
    cnt_d      = (state_q == IDLE || tick) ? '0 : cnt_q + CNT_W'(1);

    if (en_rise) overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = WAIT_TICK;
          overrun_d  = 1'b0;
          first_wr_d = 1'b1;
        end
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick) begin
          voltage_d  = wave_next;
          dir_down_d = dir_next;
          if (!hold_skip) begin
            state_d    = ISSUE;
            set_trig_d = 1'b1;
            busy_d     = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
        to_d    = '0;
      end
      WAIT_DONE: begin
        if (set_done) begin
          cur_vol_d  = voltage_q;
          first_wr_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = enable ? WAIT_TICK : IDLE;
        end else if (to_q == TO_MAX) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = enable ? WAIT_TICK : IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A tick that lands while a write is in flight is dropped, never queued.
    if (tick && writing) overrun_d = 1'b1;
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      to_q       <= '0;
      voltage_q  <= 8'h00;
      cur_vol_q  <= 8'h00;
      set_trig_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
      dir_down_q <= 1'b0;
      first_wr_q <= 1'b1;
      en_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      voltage_q  <= voltage_d;
      cur_vol_q  <= cur_vol_d;
      set_trig_q <= set_trig_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      overrun_q  <= overrun_d;
      dir_down_q <= dir_down_d;
      first_wr_q <= first_wr_d;
      en_prev_q  <= en_prev_d;
    end
  end

  assign voltage  = voltage_q;
  assign cur_vol  = cur_vol_q;
  assign set_trig = set_trig_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_dac5571_wave_sched.sv
// Bench for dac5571_wave_sched: a cycle-timed event model checked every cycle,
// plus literal expectations for the documented waveform sequences.
`timescale 1ns/1ps
module tb_dac5571_wave_sched;

  localparam int DIV = 8;
  localparam int TMO = 20;

  logic       sclk = 1'b0;
  logic       nrst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] step = 8'h00;
  logic [7:0] hold_vol = 8'h00;
  logic       resp_sd = 1'b0;
  logic       stray_sd = 1'b0;
  logic       set_done;
  logic [7:0] voltage;
  logic       set_trig;
  logic [7:0] cur_vol;
  logic       busy;
  logic       err;
  logic       overrun;

  assign set_done = resp_sd | stray_sd;

  dac5571_wave_sched #(.UPDATE_DIV(DIV), .TIMEOUT_CYC(TMO)) dut (
    .sclk(sclk), .nrst(nrst), .enable(enable), .mode(mode), .step(step),
    .hold_vol(hold_vol), .voltage(voltage), .set_trig(set_trig),
    .set_done(set_done), .cur_vol(cur_vol), .busy(busy), .err(err),
    .overrun(overrun)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: time-based view of the schedule. Ticks fall every DIV cycles from
  // the cycle the scheduler starts; a write occupies its trigger cycle plus up
  // to TMO cycles waiting for completion.
  int m_phase, m_t0, m_trig_c, m_dir_down, m_first, m_en_prev;
  int e_volt, e_cur, e_trig, e_busy, e_err, e_ov;

  task automatic model_reset();
    m_phase = 0; m_t0 = 0; m_trig_c = 0; m_dir_down = 0; m_first = 1; m_en_prev = 0;
    e_volt = 0; e_cur = 0; e_trig = 0; e_busy = 0; e_err = 0; e_ov = 0;
  endtask

  task automatic model_step();
    int n, nxt, s;
    bit tick, hold_m, done;
    n    = cyc;
    s    = int'(step);
    tick = (m_phase != 0) && (((n - m_t0) % DIV) == DIV - 1);
    done = 1'b0;
    e_trig = 0;
    e_err  = 0;
    if (enable && !m_en_prev) e_ov = 0;
    case (m_phase)
      0: if (enable) begin
        m_phase = 1; m_t0 = n + 1; e_ov = 0; m_first = 1;
      end
      1: if (!enable) begin
        m_phase = 0;
      end else if (tick) begin
        hold_m = (mode == 2'b00) || (mode == 2'b11);
        nxt = int'(hold_vol);
        if (mode == 2'b01) begin
          nxt = (e_cur + s) % 256;
        end else if (mode == 2'b10) begin
          if (m_dir_down == 0) begin
            nxt = (e_cur + s > 255) ? 255 : e_cur + s;
            if (nxt == 255) m_dir_down = 1;
          end else begin
            nxt = (e_cur - s < 0) ? 0 : e_cur - s;
            if (nxt == 0) m_dir_down = 0;
          end
        end
        e_volt = nxt;
        if (!(hold_m && nxt == e_cur && m_first == 0)) begin
          m_phase = 2; m_trig_c = n + 1; e_trig = 1; e_busy = 1;
        end
      end
      default: begin
        if (tick) e_ov = 1;
        if (n > m_trig_c && set_done) begin
          e_cur = e_volt; m_first = 0; done = 1'b1;
        end else if (n == m_trig_c + TMO) begin
          e_err = 1; done = 1'b1;
        end
        if (done) begin
          e_busy = 0;
          m_phase = enable ? 1 : 0;
        end
      end
    endcase
    m_en_prev = int'(enable);
  endtask

  int trig_v[$];
  int trig_c[$];
  int err_c[$];

  initial model_reset();

  always @(negedge sclk) begin
    if (!nrst) model_reset();
    chk("voltage", voltage, e_volt);
    chk("cur_vol", cur_vol, e_cur);
    chk("set_trig", set_trig, e_trig);
    chk("busy", busy, e_busy);
    chk("err", err, e_err);
    chk("overrun", overrun, e_ov);
    if (set_trig) begin
      trig_v.push_back(int'(voltage));
      trig_c.push_back(cyc);
      $display("cycle %0d: write 0x%02h", cyc, voltage);
    end
    if (err) begin
      err_c.push_back(cyc);
      $display("cycle %0d: write timeout", cyc);
    end
    if (nrst) model_step();
  end

  // Write-engine stand-in: completes each request resp_dly cycles after set_trig.
  int resp_dly = 3;
  initial forever begin
    @(negedge sclk);
    if (nrst && set_trig && resp_dly > 0) begin
      repeat (resp_dly) @(posedge sclk);
      #1 resp_sd = 1'b1;
      @(posedge sclk);
      #1 resp_sd = 1'b0;
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge sclk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge sclk);
    #1 nrst = 1'b0;
    enable = 1'b0;
    cycles(2);
    nrst = 1'b1;
    trig_v.delete();
    trig_c.delete();
    err_c.delete();
  endtask

  task automatic wait_trigs(input int k, input int budget, input string name);
    int b = 0;
    while (trig_v.size() < k && b < budget) begin
      cycles(1);
      b++;
    end
    chk(name, int'(trig_v.size() >= k), 1);
  endtask

  int tri_exp[7] = '{8'h70, 8'hE0, 8'hFF, 8'h8F, 8'h1F, 8'h00, 8'h70};

  initial begin
    cycles(3);
    chk("reset_voltage", voltage, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    nrst = 1'b1;
    cycles(2);

    // Sawtooth with wrap.
    do_reset();
    mode = 2'b01; step = 8'h60; resp_dly = 3; enable = 1'b1;
    wait_trigs(3, 60, "saw_trig_timeout");
    chk("saw_v0", trig_v[0], 8'h60);
    chk("saw_v1", trig_v[1], 8'hC0);
    chk("saw_v2_wrap", trig_v[2], 8'h20);
    chk("saw_spacing01", trig_c[1] - trig_c[0], 8);
    chk("saw_spacing12", trig_c[2] - trig_c[1], 8);
    enable = 1'b0;
    cycles(15);

    // Triangle with flips at both rails.
    do_reset();
    mode = 2'b10; step = 8'h70; enable = 1'b1;
    wait_trigs(7, 100, "tri_trig_timeout");
    for (int i = 0; i < 7; i++) chk($sformatf("tri_v%0d", i), trig_v[i], tri_exp[i]);
    enable = 1'b0;
    cycles(15);

    // Hold: one write, then silence until hold_vol changes mid-period.
    do_reset();
    mode = 2'b00; hold_vol = 8'h55; enable = 1'b1;
    cycles(45);
    chk("hold_count1", trig_v.size(), 1);
    chk("hold_v0", trig_v[0], 8'h55);
    hold_vol = 8'h56;
    cycles(40);
    chk("hold_count2", trig_v.size(), 2);
    chk("hold_v1", trig_v[1], 8'h56);
    enable = 1'b0;
    cycles(10);

    // Write engine never answers: timeout, then a stray set_done must be ignored.
    do_reset();
    mode = 2'b01; step = 8'h10; resp_dly = -1; enable = 1'b1;
    wait_trigs(1, 30, "tmo_trig_timeout");
    for (int b = 0; b < 40 && err_c.size() == 0; b++) cycles(1);
    chk("tmo_err_seen", err_c.size(), 1);
    chk("tmo_err_delay", err_c[0] - trig_c[0], TMO + 1);
    chk("tmo_cur_vol", cur_vol, 0);
    stray_sd = 1'b1;
    cycles(1);
    stray_sd = 1'b0;
    chk("stray_cur_vol", cur_vol, 0);
    wait_trigs(2, 40, "tmo_retry_timeout");
    chk("tmo_retry_v", trig_v[1], 8'h10);
    chk("tmo_retry_spacing", trig_c[1] - trig_c[0], 24);
    chk("tmo_overrun", overrun, 1);
    enable = 1'b0;
    cycles(30);

    // Slow completion: dropped tick sets overrun, sticky until enable rises.
    do_reset();
    mode = 2'b01; step = 8'h01; resp_dly = 12; enable = 1'b1;
    wait_trigs(2, 60, "ovr_trig_timeout");
    chk("ovr_spacing", trig_c[1] - trig_c[0], 16);
    chk("ovr_set", overrun, 1);
    enable = 1'b0;
    cycles(20);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_cur_vol", cur_vol, 8'h02);
    enable = 1'b1;
    cycles(2);
    chk("ovr_cleared", overrun, 0);
    enable = 1'b0;
    cycles(5);

    // Asynchronous reset in the middle of a write; the late set_done is ignored.
    do_reset();
    mode = 2'b01; step = 8'h20; resp_dly = 5; enable = 1'b1;
    wait_trigs(1, 30, "rst_trig_timeout");
    cycles(2);
    #2 nrst = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst_voltage", voltage, 0);
    chk("arst_cur_vol", cur_vol, 0);
    chk("arst_busy", busy, 0);
    chk("arst_trig", set_trig, 0);
    chk("arst_err", err, 0);
    chk("arst_overrun", overrun, 0);
    cycles(1);
    nrst = 1'b1;
    cycles(8);
    chk("late_done_cur_vol", cur_vol, 0);
    chk("late_done_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000 ns");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dac5571_wave_sched.md
DAC5571_WAVE_SCHED -- requirements
Module: dac5571_wave_sched

Interface
REQ-001 Parameter UPDATE_DIV, default 50_000; sclk cycles per update tick (1 kHz at 50 MHz); legal range 2 or more.
REQ-002 Parameter TIMEOUT_CYC, default 100_000; maximum sclk cycles to wait for set_done before aborting a write.
REQ-003 sclk  input  1  system clock; the block has one clock and all logic is on its rising edge.
REQ-004 nrst  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  level signal; high runs the scheduler.
REQ-006 mode  input  2  00 hold, 01 sawtooth, 10 triangle, 11 treated as hold.
REQ-007 step  input  8  increment or decrement applied per tick in sawtooth and triangle modes.
REQ-008 hold_vol  input  8  target code in hold mode.
REQ-009 voltage  output  8  code presented to the DAC write engine; connects to the engine's voltage input.
REQ-010 set_trig  output  1  one-cycle write request to the DAC write engine.
REQ-011 set_done  input  1  one-cycle completion pulse from the DAC write engine.
REQ-012 cur_vol  output  8  last code confirmed written by set_done.
REQ-013 busy  output  1  high from the set_trig cycle through the cycle that set_done or a timeout is accepted.
REQ-014 err  output  1  one-cycle pulse when a write times out.
REQ-015 overrun  output  1  sticky flag: a tick arrived while busy; cleared only by reset or by an enable rising edge.

Function
REQ-016 States SHALL be IDLE, WAIT_TICK, ISSUE and WAIT_DONE.
REQ-017 IDLE: when enable is high, go to WAIT_TICK, clear the tick counter, clear overrun and set the first_wr flag.
REQ-018 Tick counter: counts 0..UPDATE_DIV-1 while the state is not IDLE, then wraps; a tick is the cycle the count equals UPDATE_DIV-1.
REQ-019 WAIT_TICK on a tick:
- compute next (REQ-023..026) and latch it into voltage;
- go to ISSUE, except in hold mode when next equals cur_vol and first_wr is 0, where the state stays in WAIT_TICK and nothing is written.
REQ-020 ISSUE: drive set_trig high for exactly one cycle, then go to WAIT_DONE.
REQ-021 voltage SHALL stay stable from ISSUE until the write completes.
REQ-022 WAIT_DONE:
- on set_done: cur_vol <= voltage, first_wr <= 0, go to WAIT_TICK;
- after TIMEOUT_CYC cycles without set_done: pulse err, leave cur_vol unchanged, go to WAIT_TICK.
REQ-023 Sawtooth: next = (cur_vol + step) mod 256; the value wraps.
REQ-024 Triangle, direction up: next = min(cur_vol + step, 255) using a 9-bit sum; the direction flips to down when next = 255.
REQ-025 Triangle, direction down: next = cur_vol - step if cur_vol >= step, else 0; the direction flips to up when next = 0.
REQ-026 step = 0 in sawtooth or triangle: next = cur_vol and the write is still issued.
REQ-027 mode, step and hold_vol are sampled only on a tick; a change in any other cycle has no effect until the next tick.
REQ-028 A tick while in ISSUE or WAIT_DONE is dropped and sets overrun; no write is queued.
REQ-029 enable falling while in WAIT_TICK: go to IDLE next cycle.
REQ-030 enable falling while in ISSUE or WAIT_DONE: complete the write (set_done or timeout), then go to IDLE.
REQ-031 In IDLE, voltage and cur_vol hold their values.
REQ-032 set_done arriving outside WAIT_DONE SHALL be ignored.

Reset
REQ-033 While nrst is low:
- state = IDLE; voltage, cur_vol and tick counter = 0;
- set_trig, busy, err and overrun = 0; triangle direction = up; first_wr = 1.
REQ-034 Reset asserted mid-write aborts the write immediately with no err pulse.

Verification
REQ-035 Use UPDATE_DIV=8 and TIMEOUT_CYC=20. Saw mode, step=0x60, set_done 3 cycles after each set_trig -> voltage sequence 0x60, 0xC0, 0x20 (wrap); set_trig spaced 8 cycles apart.
REQ-036 Triangle mode, step=0x70 -> 0x70, 0xE0, 0xFF, 0x8F, 0x1F, 0x00, 0x70; direction flips at 0xFF and at 0x00.
REQ-037 Hold mode, hold_vol=0x55 -> one write of 0x55, then no set_trig on later ticks; change hold_vol to 0x56 -> exactly one further write.
REQ-038 Write engine never returns set_done -> err pulses 20 cycles after entering WAIT_DONE, cur_vol unchanged, and the next tick issues a new write.
REQ-039 set_done delayed 12 cycles (longer than UPDATE_DIV) -> overrun=1 and the dropped tick issues no write.
REQ-040 nrst pulsed low during WAIT_DONE -> all outputs 0 asynchronously; a late set_done is ignored.
